fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of the instruction memory. Owns the program counter and drives the memory's PC address. Captures the combinational instruction word returned in the same cycle into an IF/ID pipeline register for the decoder. Handles stall, redirect/flush and misaligned-target faults.

Parameters:
ADDRESS_WIDTH, 32, PC and address width in bits
DATA_WIDTH, 32, instruction word width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
pc_o  out  ADDRESS_WIDTH  fetch address to the instruction memory
instr_i  in  DATA_WIDTH  instruction word at pc_o, combinational, same cycle
stall_i  in  1  hold PC and IF/ID contents
redirect_i  in  1  load redirect_target_i as the next PC and flush IF/ID (branch, jump or trap)
redirect_target_i  in  ADDRESS_WIDTH  redirect destination
ifid_valid_o  out  1  IF/ID holds a real instruction
ifid_instr_o  out  DATA_WIDTH  latched instruction
ifid_pc_o  out  ADDRESS_WIDTH  PC of the latched instruction
ifid_pc_plus4_o  out  ADDRESS_WIDTH  ifid_pc_o + 4
fault_o  out  1  misaligned fetch fault, sticky while in FAULT
fault_addr_o  out  ADDRESS_WIDTH  offending target address
perf_fetched_o  out  32  count of valid instructions latched
perf_bubbles_o  out  32  count of cycles latching a bubble

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Reset has priority over all other inputs.
- Reset values:
  - pc_o = RESET_PC
  - ifid_valid_o = 0, ifid_instr_o = 32'h0000_0013 (NOP), ifid_pc_o = 0, ifid_pc_plus4_o = 4
  - fault_o = 0, fault_addr_o = 0
  - state = BOOT
  - perf counters = 0
- States:
  - BOOT: exactly one cycle after reset. IF/ID receives a bubble (valid 0). PC is not advanced. Always goes to RUN.
  - RUN: normal fetch.
  - FAULT: PC is frozen and IF/ID receives bubbles.
- Per-cycle priority in RUN: redirect_i > stall_i > sequential.
  - Sequential: IF/ID takes {instr_i, pc_o, pc_o+4}, valid 1, and pc_o <= pc_o + 4. Latency is one cycle from pc_o to ifid_*.
  - stall_i=1 with no redirect: pc_o and all ifid_* hold. Valid is held, not cleared.
  - redirect_i=1 with an aligned target (target[1:0]==0): pc_o <= target and IF/ID is flushed (valid 0, instr NOP). A simultaneous stall_i is ignored.
  - redirect_i=1 with a misaligned target: enter FAULT, fault_o <= 1, fault_addr_o <= target, pc_o holds, IF/ID is flushed.
- In FAULT:
  - A redirect with an aligned target clears fault_o, loads pc_o and returns to RUN; that cycle's IF/ID is a bubble.
  - A misaligned redirect updates fault_addr_o and stays in FAULT.
  - stall_i has no effect.
- Arithmetic: pc+4 wraps modulo 2^ADDRESS_WIDTH (32'hFFFF_FFFC -> 0, no fault).
- Reset asserted mid-stall, mid-redirect or in FAULT: reset values apply on the next edge, with no residual state.
- pc_o is a pure register output with no combinational path from any input.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined:
  - perf_fetched_o increments on every edge that latches valid=1 into IF/ID.
  - perf_bubbles_o increments on every edge that latches valid=0 (BOOT, flush, FAULT).
  - Stall cycles increment neither counter.
  - Both counters are 32-bit and wrap.
- Not defined: both outputs are tied to 0 and no counter flops are synthesised.

Decomposition:
- fetch_pkg holds:
  - fetch_state_t enum {BOOT, RUN, FAULT}
  - NOP_INSTR = 32'h0000_0013
  - INSTR_BYTES = 4
- One sub-module, fetch_ifid_reg: the IF/ID register with load, hold and flush controls. Flush has priority over hold. The top level contains the PC, the FSM and the counters.

Test Plan:
- Reset, then release with no stall or redirect -> first cycle ifid_valid_o=0 (BOOT); then pc_o steps 0,4,8,... and ifid_pc_o lags pc_o by one cycle with ifid_instr_o = the memory word at that PC.
- stall_i high for 3 cycles at pc_o=0x8 -> pc_o stays 0x8 and ifid_* is unchanged for 3 cycles; sequencing resumes to 0xC.
- redirect_i with target 0x100 together with stall_i=1 -> next cycle pc_o=0x100 and ifid_valid_o=0; the following cycle ifid_pc_o=0x100 and valid=1.
- redirect_i with target 0x102 -> fault_o=1, fault_addr_o=0x102, pc_o frozen, bubbles latched; then redirect to 0x200 -> fault_o=0 and fetch resumes at 0x200.
- Force pc_o to 32'hFFFF_FFFC via redirect -> next PC is 0x0 and ifid_pc_plus4_o=0x0, no fault.
- With FETCH_PERF_CNT_EN defined: reset, 10 sequential cycles, 2 stall cycles, 1 redirect -> perf_fetched_o=10 and perf_bubbles_o=2 (BOOT + flush). Without the macro -> both outputs remain 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, RUN, FAULT} fetch_state_t;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          INSTR_BYTES = 4;
endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: load captures a new instruction, flush inserts a
// NOP bubble (and wins over hold), otherwise contents hold.
module fetch_ifid_reg
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_i,
  input  logic                     flush_i,
  input  logic [DATA_WIDTH-1:0]    instr_i,
  input  logic [ADDRESS_WIDTH-1:0] pc_i,
  output logic                     valid_o,
  output logic [DATA_WIDTH-1:0]    instr_o,
  output logic [ADDRESS_WIDTH-1:0] pc_o,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_o
);
  logic                     valid_q, valid_d;
  logic [DATA_WIDTH-1:0]    instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d, pc_plus4_q, pc_plus4_d;

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    // A flushed slot keeps its stale PC; only valid/instr mark it as a bubble.
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = DATA_WIDTH'(NOP_INSTR);
    end else if (load_i) begin
      valid_d    = 1'b1;
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_i + ADDRESS_WIDTH'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= DATA_WIDTH'(NOP_INSTR);
      pc_q       <= '0;
      pc_plus4_q <= ADDRESS_WIDTH'(INSTR_BYTES);
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, BOOT/RUN/FAULT control and IF/ID latch.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                         ADDRESS_WIDTH = 32,
  parameter int                         DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] pc_o,
  input  logic [DATA_WIDTH-1:0]    instr_i,
  input  logic                     stall_i,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target_i,
  output logic                     ifid_valid_o,
  output logic [DATA_WIDTH-1:0]    ifid_instr_o,
  output logic [ADDRESS_WIDTH-1:0] ifid_pc_o,
  output logic [ADDRESS_WIDTH-1:0] ifid_pc_plus4_o,
  output logic                     fault_o,
  output logic [ADDRESS_WIDTH-1:0] fault_addr_o,
  output logic [31:0]              perf_fetched_o,
  output logic [31:0]              perf_bubbles_o
);
  fetch_state_t             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d, fault_addr_q, fault_addr_d;
  logic                     fault_q, fault_d;
  logic                     load, flush, tgt_aligned;

  assign tgt_aligned = (redirect_target_i[1:0] == 2'b00);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    load         = 1'b0;
    flush        = 1'b0;
    unique case (state_q)
      BOOT: begin
        flush   = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (redirect_i) begin
          flush = 1'b1;
          if (tgt_aligned) begin
            pc_d = redirect_target_i;
          end else begin
            state_d      = FAULT;
            fault_d      = 1'b1;
            fault_addr_d = redirect_target_i;
          end
        end else if (!stall_i) begin
          load = 1'b1;
          pc_d = pc_q + ADDRESS_WIDTH'(INSTR_BYTES);
        end
      end
      FAULT: begin
        // Stall is ignored here: the slot is a bubble every cycle.
        flush = 1'b1;
        if (redirect_i) begin
          if (tgt_aligned) begin
            pc_d    = redirect_target_i;
            fault_d = 1'b0;
            state_d = RUN;
          end else begin
            fault_addr_d = redirect_target_i;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign pc_o         = pc_q;
  assign fault_o      = fault_q;
  assign fault_addr_o = fault_addr_q;

  fetch_ifid_reg #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_ifid (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .flush_i   (flush),
    .instr_i   (instr_i),
    .pc_i      (pc_q),
    .valid_o   (ifid_valid_o),
    .instr_o   (ifid_instr_o),
    .pc_o      (ifid_pc_o),
    .pc_plus4_o(ifid_pc_plus4_o)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d, bubbles_q, bubbles_d;

  always_comb begin
    fetched_d = fetched_q + {31'd0, load};
    bubbles_d = bubbles_q + {31'd0, flush};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign perf_fetched_o = fetched_q;
  assign perf_bubbles_o = bubbles_q;
`else
  assign perf_fetched_o = '0;
  assign perf_bubbles_o = '0;
`endif
endmodule
